// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared 32-bit memory port.
// The debug unit and the CPU core both use a hold-until-ready handshake.
// The winner's request is latched into the mem_* registers. Completion is
// returned to the owner in the same cycle mem_rdy arrives. An access that
// hangs is aborted after TIMEOUT busy cycles, and the owner sees rdy and err
// together. A one-cycle GAP after every access stops a master from being
// granted again on an op it has not yet dropped.
module mem_arbiter #(
    parameter int DBG_PRIORITY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dbg_adr,
    input  logic [31:0] dbg_wdata,
    input  logic        dbg_rw,
    input  logic        dbg_op,
    output logic        dbg_rdy,
    output logic        dbg_err,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rw,
    input  logic        cpu_op,
    output logic        cpu_rdy,
    output logic        cpu_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    output logic        mem_op,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        grant_dbg,
    output logic        grant_cpu
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // The counter only has to reach TIMEOUT-1. It keeps one bit even when the
    // timeout is disabled, so the declaration stays legal.
    localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic          owner_dbg_reg;   // 1 = debug owns the port, 0 = CPU
    logic          last_dbg_reg;    // 1 = last grant went to debug
    logic [CW-1:0] count_reg;
    logic [31:0]   mem_adr_reg;
    logic [31:0]   mem_wdata_reg;
    logic          mem_rw_reg;

    logic busy;
    logic any_op;
    logic pick_dbg;
    logic timeout_hit;
    logic done;

    assign busy   = (state_reg == BUSY);
    assign any_op = dbg_op | cpu_op;
    // Debug wins when it is alone, when priority is fixed, or when the CPU
    // received the previous grant.
    assign pick_dbg    = dbg_op & (~cpu_op | (DBG_PRIORITY != 0) | ~last_dbg_reg);
    assign timeout_hit = (TIMEOUT != 0) && busy && !mem_rdy && (count_reg == TO_LAST);
    assign done        = busy & (mem_rdy | timeout_hit);

    // Next-state logic: IDLE -> BUSY on any request, BUSY -> GAP on completion, GAP -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_op) state_next = BUSY;
            BUSY:    if (done) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, ownership, timeout counter and the latched memory request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_dbg_reg <= 1'b0;
            last_dbg_reg  <= 1'b0;
            count_reg     <= '0;
            mem_adr_reg   <= '0;
            mem_wdata_reg <= '0;
            mem_rw_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && any_op) begin
                owner_dbg_reg <= pick_dbg;
                last_dbg_reg  <= pick_dbg;
                count_reg     <= '0;
                mem_adr_reg   <= pick_dbg ? dbg_adr   : cpu_adr;
                mem_wdata_reg <= pick_dbg ? dbg_wdata : cpu_wdata;
                mem_rw_reg    <= pick_dbg ? dbg_rw    : cpu_rw;
            end else if (busy && !mem_rdy) begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign mem_op    = busy;
    assign mem_adr   = mem_adr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_rw    = mem_rw_reg;
    // Read data passes straight through. It is forced to zero on an aborted access.
    assign rdata     = (busy && !timeout_hit) ? mem_rdata : 32'h0;

    // Per-master response. Index 1 is debug and index 0 is the CPU. Every
    // response is held low while reset is asserted.
    logic [1:0] own_vec;
    logic [1:0] rdy_vec;
    logic [1:0] err_vec;
    logic [1:0] grant_vec;

    assign own_vec = {owner_dbg_reg, ~owner_dbg_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign grant_vec[gi] = busy        & own_vec[gi] & ~reset;
            assign rdy_vec[gi]   = done        & own_vec[gi] & ~reset;
            assign err_vec[gi]   = timeout_hit & own_vec[gi] & ~reset;
        end
    endgenerate

    assign dbg_rdy   = rdy_vec[1];
    assign cpu_rdy   = rdy_vec[0];
    assign dbg_err   = err_vec[1];
    assign cpu_err   = err_vec[0];
    assign grant_dbg = grant_vec[1];
    assign grant_cpu = grant_vec[0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. u_a runs with fixed debug priority and u_b with
// round-robin; both have TIMEOUT = 4. The two share the master-side inputs.
// Each has its own memory model that raises mem_rdy after a programmable
// number of BUSY cycles (lat = 0 means mem_rdy never comes). Expected
// completions are queued when stimulus is applied and popped whenever a rdy
// pulse appears.
module tb_mem_arbiter;

    typedef struct packed {
        logic        dbg;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dbg_adr, dbg_wdata, cpu_adr, cpu_wdata;
    logic        dbg_rw, dbg_op, cpu_rw, cpu_op;

    logic        dbg_rdy_a, dbg_err_a, cpu_rdy_a, cpu_err_a, mem_rw_a, mem_op_a, grant_dbg_a, grant_cpu_a;
    logic [31:0] rdata_a, mem_adr_a, mem_wdata_a, mem_rdata_a;
    logic        mem_rdy_a;
    logic        dbg_rdy_b, dbg_err_b, cpu_rdy_b, cpu_err_b, mem_rw_b, mem_op_b, grant_dbg_b, grant_cpu_b;
    logic [31:0] rdata_b, mem_adr_b, mem_wdata_b, mem_rdata_b;
    logic        mem_rdy_b;

    int   lat = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] adr);
        return adr ^ 32'hDEADBFEF;
    endfunction

    assign mem_rdata_a = mem_val(mem_adr_a);
    assign mem_rdata_b = mem_val(mem_adr_b);
    assign mem_rdy_a   = mem_op_a && (lat != 0) && (cnt_a == lat - 1);
    assign mem_rdy_b   = mem_op_b && (lat != 0) && (cnt_b == lat - 1);

    always @(posedge clk) begin
        cnt_a <= (mem_op_a && !mem_rdy_a) ? cnt_a + 1 : 0;
        cnt_b <= (mem_op_b && !mem_rdy_b) ? cnt_b + 1 : 0;
    end

    mem_arbiter #(.DBG_PRIORITY(1), .TIMEOUT(4)) u_a (
        .clk(clk), .reset(rst),
        .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata), .dbg_rw(dbg_rw), .dbg_op(dbg_op),
        .dbg_rdy(dbg_rdy_a), .dbg_err(dbg_err_a),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_op(cpu_op),
        .cpu_rdy(cpu_rdy_a), .cpu_err(cpu_err_a),
        .rdata(rdata_a), .mem_adr(mem_adr_a), .mem_wdata(mem_wdata_a), .mem_rw(mem_rw_a),
        .mem_op(mem_op_a), .mem_rdata(mem_rdata_a), .mem_rdy(mem_rdy_a),
        .grant_dbg(grant_dbg_a), .grant_cpu(grant_cpu_a)
    );

    mem_arbiter #(.DBG_PRIORITY(0), .TIMEOUT(4)) u_b (
        .clk(clk), .reset(rst),
        .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata), .dbg_rw(dbg_rw), .dbg_op(dbg_op),
        .dbg_rdy(dbg_rdy_b), .dbg_err(dbg_err_b),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw), .cpu_op(cpu_op),
        .cpu_rdy(cpu_rdy_b), .cpu_err(cpu_err_b),
        .rdata(rdata_b), .mem_adr(mem_adr_b), .mem_wdata(mem_wdata_b), .mem_rw(mem_rw_b),
        .mem_op(mem_op_b), .mem_rdata(mem_rdata_b), .mem_rdy(mem_rdy_b),
        .grant_dbg(grant_dbg_b), .grant_cpu(grant_cpu_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push2(input logic dbg_a, input logic dbg_b, input logic err,
                         input logic [31:0] data_a, input logic [31:0] data_b);
        exp_t e;
        e.dbg = dbg_a; e.err = err; e.data = data_a; qa.push_back(e);
        e.dbg = dbg_b; e.err = err; e.data = data_b; qb.push_back(e);
    endtask

    task automatic score(input int sel, input logic dr, input logic cr, input logic de,
                         input logic ce, input logic [31:0] rd);
        exp_t  e;
        string p;
        int    depth;
        p = (sel == 0) ? "a_" : "b_";
        if (!(dr || cr)) begin
            if (de || ce) chk({p, "err_without_rdy"}, {de, ce}, 0);
            return;
        end
        depth = (sel == 0) ? qa.size() : qb.size();
        if (depth == 0) begin
            chk({p, "spurious_rdy"}, {dr, cr}, 0);
            return;
        end
        e = (sel == 0) ? qa.pop_front() : qb.pop_front();
        chk({p, "rdy_owner"}, {dr, cr}, e.dbg ? 2'b10 : 2'b01);
        chk({p, "err_owner"}, e.dbg ? de : ce, e.err);
        chk({p, "err_other"}, e.dbg ? ce : de, 0);
        chk({p, "rdata"}, rd, e.data);
        $display("txn %s owner=%s err=%0d rdata=%08h", p, e.dbg ? "dbg" : "cpu", e.err, rd);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        score(0, dbg_rdy_a, cpu_rdy_a, dbg_err_a, cpu_err_a, rdata_a);
        score(1, dbg_rdy_b, cpu_rdy_b, dbg_err_b, cpu_err_b, rdata_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dbg_adr = '0; dbg_wdata = '0; dbg_rw = 1'b1; dbg_op = 1'b0;
        cpu_adr = '0; cpu_wdata = '0; cpu_rw = 1'b1; cpu_op = 1'b0;
        repeat (3) tick();
        mid();
        chk("rst_mem_op", {mem_op_a, mem_op_b}, 0);
        chk("rst_mem_rw", {mem_rw_a, mem_rw_b}, 2'b11);
        chk("rst_mem_adr", mem_adr_a, 0);
        chk("rst_mem_wdata", mem_wdata_a, 0);
        chk("rst_outs_a", {dbg_rdy_a, dbg_err_a, cpu_rdy_a, cpu_err_a, grant_dbg_a, grant_cpu_a}, 0);
        chk("rst_outs_b", {dbg_rdy_b, dbg_err_b, cpu_rdy_b, cpu_err_b, grant_dbg_b, grant_cpu_b}, 0);
        tick(); rst = 1'b0;
        mid();
        chk("idle_mem_op", mem_op_a, 0);

        // Debug read alone; mem_rdy comes on the third BUSY cycle.
        for (int c = 0; c <= 5; c++) begin
            tick();
            if (c == 0) begin
                dbg_adr = 32'h100; dbg_rw = 1'b1; dbg_wdata = '0; dbg_op = 1'b1; lat = 3;
                push2(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
            end
            if (c == 4) dbg_op = 1'b0;
            mid();
            if (c == 0) chk("t1_op_c0", mem_op_a, 0);
            if (c == 1) begin
                chk("t1_op_c1", mem_op_a, 1);
                chk("t1_adr", mem_adr_a, 32'h100);
                chk("t1_rw", mem_rw_a, 1);
                chk("t1_grant", {grant_dbg_a, grant_cpu_a}, 2'b10);
            end
            if (c == 2) chk("t1_op_c2", mem_op_a, 1);
            if (c == 3) begin
                chk("t1_rdy", {dbg_rdy_a, cpu_rdy_a}, 2'b10);
                chk("t1_rdata", rdata_a, 32'hDEADBEEF);
            end
            if (c == 4) chk("t1_gap", {mem_op_a, grant_dbg_a, grant_cpu_a}, 0);
        end

        // Both masters requesting continuously; two-cycle memory accesses.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            tick();
            if (c == 0) begin
                dbg_adr = 32'h200; dbg_rw = 1'b1; dbg_op = 1'b1;
                cpu_adr = 32'h300; cpu_rw = 1'b0; cpu_wdata = 32'h12345678; cpu_op = 1'b1;
                lat = 2;
                push2(1'b1, 1'b1, 1'b0, mem_val(32'h200), mem_val(32'h200));
                push2(1'b1, 1'b0, 1'b0, mem_val(32'h200), mem_val(32'h300));
                push2(1'b1, 1'b1, 1'b0, mem_val(32'h200), mem_val(32'h200));
                push2(1'b1, 1'b0, 1'b0, mem_val(32'h200), mem_val(32'h300));
            end
            if (c == 15) begin
                dbg_op = 1'b0;
                push2(1'b0, 1'b0, 1'b0, mem_val(32'h300), mem_val(32'h300));
            end
            if (c == 19) cpu_op = 1'b0;
            mid();
            if (c == 1) begin
                chk("t2_adr_a_c1", mem_adr_a, 32'h200);
                chk("t2_adr_b_c1", mem_adr_b, 32'h200);
                chk("t2_grant_a_c1", {grant_dbg_a, grant_cpu_a}, 2'b10);
                chk("t2_grant_b_c1", {grant_dbg_b, grant_cpu_b}, 2'b10);
            end
            if (c == 3) chk("t2_gap_a", {mem_op_a, grant_dbg_a, grant_cpu_a}, 0);
            if (c == 5) begin
                chk("t2_prio_a_c5", {grant_dbg_a, grant_cpu_a}, 2'b10);
                chk("t2_rr_b_c5", {grant_dbg_b, grant_cpu_b}, 2'b01);
                chk("t2_adr_b_c5", mem_adr_b, 32'h300);
                chk("t2_rw_b_c5", mem_rw_b, 0);
                chk("t2_wdata_b_c5", mem_wdata_b, 32'h12345678);
            end
            if (c == 9)  chk("t2_rr_b_c9", {grant_dbg_b, grant_cpu_b}, 2'b10);
            if (c == 13) chk("t2_rr_b_c13", {grant_dbg_b, grant_cpu_b}, 2'b01);
            if (c == 17) begin
                chk("t2_cpu_a_c17", {grant_dbg_a, grant_cpu_a}, 2'b01);
                chk("t2_adr_a_c17", mem_adr_a, 32'h300);
            end
            if (c == 20) chk("t2_idle", mem_op_a, 0);
        end

        // CPU write with mem_rdy stuck low, then mem_rdy on the fourth BUSY cycle.
        for (int run = 0; run < 2; run++) begin
            for (int c = 0; c <= 6; c++) begin
                tick();
                if (c == 0) begin
                    cpu_adr = 32'h400; cpu_rw = 1'b0; cpu_wdata = 32'hCAFEF00D; cpu_op = 1'b1;
                    lat = (run == 0) ? 0 : 4;
                    if (run == 0) push2(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
                    else push2(1'b0, 1'b0, 1'b0, mem_val(32'h400), mem_val(32'h400));
                end
                if (c == 5) cpu_op = 1'b0;
                mid();
                if (c == 3) chk("t3_no_early_rdy", cpu_rdy_a, 0);
                if (c == 4) begin
                    chk("t3_rdy_err", {cpu_rdy_a, cpu_err_a}, (run == 0) ? 2'b11 : 2'b10);
                    chk("t3_rdata", rdata_a, (run == 0) ? 32'h0 : mem_val(32'h400));
                    chk("t3_dbg_quiet", {dbg_rdy_a, dbg_err_a}, 0);
                end
                if (c == 5) chk("t3_op_drop", mem_op_a, 0);
            end
        end

        // Reset in the second BUSY cycle of a debug write; a CPU read follows.
        for (int c = 0; c <= 7; c++) begin
            tick();
            if (c == 0) begin
                dbg_adr = 32'h800; dbg_rw = 1'b0; dbg_wdata = 32'h55AA55AA; dbg_op = 1'b1; lat = 2;
            end
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                rst = 1'b0; dbg_op = 1'b0;
                cpu_adr = 32'h500; cpu_rw = 1'b1; cpu_op = 1'b1;
                push2(1'b0, 1'b0, 1'b0, mem_val(32'h500), mem_val(32'h500));
            end
            if (c == 6) cpu_op = 1'b0;
            mid();
            if (c == 1) begin
                chk("t4_rw_c1", mem_rw_a, 0);
                chk("t4_adr_c1", mem_adr_a, 32'h800);
            end
            if (c == 2) chk("t4_no_rdy", {dbg_rdy_a, dbg_rdy_b}, 0);
            if (c == 3) begin
                chk("t4_op", mem_op_a, 0);
                chk("t4_rw", mem_rw_a, 1);
                chk("t4_adr", mem_adr_a, 0);
                chk("t4_wdata", mem_wdata_a, 0);
            end
            if (c == 4) begin
                chk("t4_cpu_grant", {grant_dbg_a, grant_cpu_a}, 2'b01);
                chk("t4_cpu_adr", mem_adr_a, 32'h500);
            end
        end

        // Debug holds op through the GAP cycle; a new access starts from IDLE.
        for (int c = 0; c <= 6; c++) begin
            tick();
            if (c == 0) begin
                dbg_adr = 32'h600; dbg_rw = 1'b1; dbg_op = 1'b1; lat = 1;
                push2(1'b1, 1'b1, 1'b0, mem_val(32'h600), mem_val(32'h600));
            end
            if (c == 3) begin
                dbg_adr = 32'h700;
                push2(1'b1, 1'b1, 1'b0, mem_val(32'h700), mem_val(32'h700));
            end
            if (c == 5) dbg_op = 1'b0;
            mid();
            if (c == 2) chk("t5_gap", {mem_op_a, grant_dbg_a, grant_cpu_a, dbg_rdy_a}, 0);
            if (c == 3) chk("t5_idle", mem_op_a, 0);
            if (c == 4) begin
                chk("t5_regrant", {grant_dbg_a, grant_cpu_a}, 2'b10);
                chk("t5_adr", mem_adr_a, 32'h700);
            end
        end

        repeat (2) tick();
        mid();
        chk("qa_left", qa.size(), 0);
        chk("qb_left", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter that shares the single 32-bit memory port between the debug unit (dbgu32) and the CPU core.
Each master uses the same hold-until-ready handshake: op held high with address, data and RW stable until a one-cycle rdy pulse.
The arbiter latches the winning request, drives the memory port, returns rdy and read data to the owner, and aborts hung accesses on a timeout.
It sits between dbgu32, the CPU bus interface and the memory/peripheral decoder.

Parameters:
DBG_PRIORITY, 1, 1 = debug always wins simultaneous requests; 0 = round-robin between the two masters.
TIMEOUT, 255, number of BUSY cycles without mem_rdy before the access is aborted; 0 disables the timeout.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dbg_adr  in  32  debug access address
dbg_wdata  in  32  debug write data
dbg_rw  in  1  1 = read, 0 = write
dbg_op  in  1  debug request, held until dbg_rdy
dbg_rdy  out  1  one-cycle completion pulse to debug
dbg_err  out  1  qualifies dbg_rdy: access timed out
cpu_adr  in  32  CPU access address
cpu_wdata  in  32  CPU write data
cpu_rw  in  1  1 = read, 0 = write
cpu_op  in  1  CPU request, held until cpu_rdy
cpu_rdy  out  1  one-cycle completion pulse to CPU
cpu_err  out  1  qualifies cpu_rdy: access timed out
rdata  out  32  shared read data, valid while either rdy is high
mem_adr  out  32  memory address (registered)
mem_wdata  out  32  memory write data (registered)
mem_rw  out  1  memory direction (registered)
mem_op  out  1  memory request
mem_rdata  in  32  memory read data
mem_rdy  in  1  memory completion (one or more cycles)
grant_dbg  out  1  debug owns the port (BUSY state)
grant_cpu  out  1  CPU owns the port (BUSY state)

Behaviour:
- States: IDLE, BUSY, GAP. Registers: owner (DBG/CPU), last_grant, a timeout counter of width $clog2(TIMEOUT+1) (minimum 1).
- Reset: state = IDLE, mem_op = 0, mem_rw = 1, mem_adr = 0, mem_wdata = 0, last_grant = CPU (so debug wins the first contest).
  - All rdy, err and grant outputs are 0 during and after reset.
- IDLE, no op asserted: stay in IDLE.
- IDLE, any op asserted:
  - Pick the winner (rules below).
  - Latch the winner's adr, wdata and rw into the mem_* registers.
  - Set owner, clear the counter, go to BUSY.
  - mem_op rises on the cycle after the request is first seen (1-cycle grant latency).
- Winner selection:
  - Only one op asserted: that master wins.
  - Both asserted and DBG_PRIORITY = 1: DBG wins.
  - Both asserted and DBG_PRIORITY = 0: the master other than last_grant wins. last_grant updates on every grant.
- BUSY:
  - mem_op = 1; grant_dbg or grant_cpu reflects owner.
  - Owner rdy is combinational: owner_rdy = mem_rdy.
  - rdata = mem_rdata (pass-through, zero added latency).
  - On mem_rdy: go to GAP.
  - No mem_rdy: increment the counter.
- Timeout (TIMEOUT != 0):
  - If counter == TIMEOUT-1 and mem_rdy = 0: pulse owner rdy and err together for that cycle, force rdata = 0, go to GAP.
  - mem_rdy in the same cycle as the timeout: normal completion, err = 0.
- GAP:
  - mem_op = 0, no grants, no rdy.
  - Return to IDLE next cycle.
  - Masters drop op on the edge that samples rdy; GAP guarantees a stale op is never re-granted.
  - Minimum spacing between accesses: 3 cycles (IDLE → BUSY → GAP).
- Master inputs are ignored while in BUSY or GAP; a non-owner simply waits with op held high.
- The non-owner's rdy and err stay 0 at all times.
- Requests are never dropped. With DBG_PRIORITY = 1, continuous debug traffic may starve the CPU; this is intended, because debug halts the CPU.
- Reset asserted mid-BUSY: mem_op falls on the next edge and no rdy pulse is produced.
- mem_rdy while not BUSY: ignored.

Test Plan:
- Debug read alone: dbg_adr = 0x100, dbg_rw = 1, dbg_op high at cycle 0; mem_rdy pulses at cycle 3 with mem_rdata = 0xDEADBEEF -> mem_op = 1 in cycles 1–3, mem_adr = 0x100, dbg_rdy = 1 and rdata = 0xDEADBEEF at cycle 3, cpu_rdy never asserted, mem_op = 0 at cycle 4.
- Simultaneous requests, DBG_PRIORITY = 1: both ops high, each mem access 2 cycles -> debug served first, CPU granted only after the GAP; mem_adr switches from dbg_adr to cpu_adr.
- Round-robin, DBG_PRIORITY = 0: both ops held high for 4 accesses -> grant order DBG, CPU, DBG, CPU.
- Timeout, TIMEOUT = 4: cpu_op write with mem_rdy stuck low -> cpu_rdy = cpu_err = 1 on the 4th BUSY cycle, rdata = 0, mem_op low on the next cycle; separately, mem_rdy arriving on the 4th cycle -> cpu_rdy = 1, cpu_err = 0.
- Reset mid-BUSY: reset asserted 2 cycles into a debug access -> mem_op = 0, mem_rw = 1, mem_adr = 0 on the next edge, no dbg_rdy; after release, a pending cpu_op is granted normally.
- Stale-op guard: master keeps op high one extra cycle after rdy -> the GAP cycle shows no grant; a new access starts from IDLE the following cycle.
